elastic_pipe: RTL and testbench
===============================

Name: elastic_pipe

Overview:
- Parametrised successor to the single enabled/reset flop: a chain of DEPTH enabled registers, each with its own valid bit and a valid/ready handshake.
- Provides bubble collapsing, per-stage stall, flush, and an occupancy count.
- Used between pixel-pipeline stages of the VGA/snake datapath (e.g. tile lookup -> sprite ROM -> colour mux) where a downstream stage can stall.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of register stages (>=1); elaboration error if 0.
- RESET_VAL, '0, WIDTH-bit value loaded into every data register on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  upstream has data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  payload
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  stage DEPTH-1 data
- count  output  $clog2(DEPTH+2)  number of valid entries held

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset: all stage valids <= 0; all stage data <= RESET_VAL; out_valid=0, out_data=RESET_VAL, count=0. Reset has priority over flush and over any transfer. Reset mid-stream discards contents without emitting them.
- Stage rule, i=0..DEPTH-1:
  - ready_i = !v_i | ready_(i+1); ready_DEPTH = out_ready.
  - Stage i loads when ready_i: v_i <= v_(i-1) (in_valid for i=0), d_i <= d_(i-1) (in_data for i=0).
  - Data is loaded only when the incoming valid is 1; otherwise data is held and only valid clears.
- in_ready = ready_0 & !flush. Combinational from out_ready through the chain (without the optional feature).
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- Latency: DEPTH cycles from an input transfer to out_valid when never stalled. Throughput is 1/cycle at steady state.
- Stall: out_ready=0 holds stage DEPTH-1; upstream bubbles collapse until every stage is full, then in_ready=0. Data in a valid stage never changes while that stage is not ready.
- Flush: next cycle all v_i=0; data regs hold. in_ready=0 during flush, so a simultaneous in_valid is dropped. An out transfer in the flush cycle is still counted as consumed.
- count: registered, equals the number of set valid bits (plus skid, below). Updated +1/-1/0 per the input/output transfers of that cycle; 0 after flush.
- Full: count==DEPTH (DEPTH+1 with skid) implies in_ready=0 unless out_ready=1.
- Empty: count==0 implies out_valid=0. No combinational in->out bypass; an empty pipe still takes DEPTH cycles.

Optional Feature:
- Macro: ELASTIC_PIPE_SKID_EN.
- Defined:
  - Adds one WIDTH-bit skid register plus valid bit ahead of stage 0.
  - in_ready = !skid_v, a registered output with no combinational path from out_ready; not gated by flush.
  - If in_valid & in_ready & !ready_0, data goes into skid. When ready_0, skid drains into stage 0 before new input.
  - Latency is unchanged when unstalled.
  - count includes skid_v; flush and reset also clear skid_v.
- Undefined: no skid logic; count never exceeds DEPTH.

Decomposition:
- Package elastic_pipe_pkg: function cnt_w(depth) = $clog2(depth+2), and a localparam for minimum DEPTH. No typedefs are needed beyond the parametrised logic vectors.
- Sub-module pipe_stage (WIDTH, RESET_VAL):
  - Inputs clk, reset, flush, load, vin, din; outputs v, q.
  - A valid-tracked enabled flop, instantiated DEPTH times via generate.
  - The ready chain and count live in the top.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, reset 2 cycles -> out_valid=0, out_data=A5, count=0, in_ready=1.
- Streaming: out_ready=1, push 10,11,12,13 on consecutive cycles -> out_valid first rises 3 cycles after first push; outputs 10..13 on consecutive cycles; count peaks at 3.
- Stall/backpressure: out_ready=0, push 5 values -> first 3 accepted, in_ready=0 on 4th, count=3. Raise out_ready -> 1,2,3 out in order, then 4,5, no loss or duplication.
- Bubbles: push 20, idle 2 cycles, push 21, out_ready=0 -> both collapse to stages 2 and 1, count=2. Release -> 20 then 21 back-to-back.
- Flush: 3 entries held, assert flush with in_valid=1, in_data=99 -> next cycle count=0, out_valid=0, 99 never emitted.
- ELASTIC_PIPE_SKID_EN: DEPTH=2, out_ready=0, push 4 values -> 3 accepted, count=3, in_ready low one cycle after 3rd accept. in_ready never toggles combinationally with out_ready (check with a same-cycle out_ready pulse).

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline.
package elastic_pipe_pkg;

  // Smallest legal number of register stages.
  localparam int MIN_DEPTH = 1;

  // Width of the occupancy counter. It must hold DEPTH+1 when the skid
  // entry is built in.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: an enabled data flop with its own valid bit.
module pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             v,
  output logic [WIDTH-1:0] q
);

  // Valid follows the upstream valid on load. Data only moves when a real
  // beat arrives, so a bubble passing through leaves the old payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      v <= 1'b0;
      q <= RESET_VAL;
    end else begin
      if (flush)     v <= 1'b0;
      else if (load) v <= vin;
      if (load && vin && !flush) q <= din;
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic register chain with valid/ready handshake, bubble collapsing,
// flush and occupancy count.
// Optional macro ELASTIC_PIPE_SKID_EN adds a skid entry ahead of stage 0 so
// that in_ready becomes a registered signal.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < MIN_DEPTH) begin : g_bad_depth
    $error("elastic_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0]            v, vin;
  logic [DEPTH-1:0][WIDTH-1:0] q, din;
  logic [DEPTH:0]              rdy;
  logic                        s0_v;
  logic [WIDTH-1:0]            s0_d;
  logic                        in_xfer, out_xfer;

  // Ready ripples back from the output: a stage can load if it is empty or
  // its successor is loading this cycle.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--)
      rdy[i] = !v[i] | rdy[i+1];
  end

  // Each stage is fed by its predecessor; stage 0 by the entry source.
  always_comb begin
    vin    = '0;
    din    = '0;
    vin[0] = s0_v;
    din[0] = s0_d;
    for (int i = 1; i < DEPTH; i++) begin
      vin[i] = v[i-1];
      din[i] = q[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk  (clk),
      .reset(reset),
      .flush(flush),
      .load (rdy[i]),
      .vin  (vin[i]),
      .din  (din[i]),
      .v    (v[i]),
      .q    (q[i])
    );
  end

`ifdef ELASTIC_PIPE_SKID_EN
  logic             skid_v;
  logic [WIDTH-1:0] skid_d;

  // Skid catches a beat accepted while stage 0 is blocked and hands it to
  // stage 0 ahead of any new input once the chain moves again.
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_v <= 1'b0;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      skid_v <= 1'b0;
    end else if (skid_v) begin
      if (rdy[0]) skid_v <= 1'b0;
    end else if (in_valid && !rdy[0]) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end
  end

  assign in_ready = !skid_v;
  assign s0_v     = skid_v | in_valid;
  assign s0_d     = skid_v ? skid_d : in_data;
`else
  assign in_ready = rdy[0] & !flush;
  assign s0_v     = in_valid;
  assign s0_d     = in_data;
`endif

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = v[DEPTH-1] & out_ready;
  assign out_valid = v[DEPTH-1];
  assign out_data  = q[DEPTH-1];

  // Occupancy tracks handshakes rather than re-counting valid bits.
  always_ff @(posedge clk) begin
    if (reset || flush) count <= '0;
    else                count <= count + CW'(in_xfer) - CW'(out_xfer);
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed bench for elastic_pipe. Skid scenario is built when
// ELASTIC_PIPE_SKID_EN is defined (DEPTH=2), otherwise DEPTH=3.
module tb_elastic_pipe;
  localparam int W = 8;
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 3;
`endif
  localparam logic [W-1:0] RV = 8'hA5;
  localparam int CW = elastic_pipe_pkg::cnt_w(D);

  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [CW-1:0] count;
  int n_cmp = 0, n_err = 0;

  elastic_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1; in_valid = 0; out_ready = 1; flush = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== RV) begin n_err++; $display("FAIL reset_data: got %0h want %0h", out_data, RV); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tick();
  endtask

`ifndef ELASTIC_PIPE_SKID_EN
  task automatic test_streaming();
    int peak = 0;
    int exp_cnt;
    logic exp_v;
    out_ready = 1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      in_data  = W'(10 + c);
      #1;
      exp_v   = (c >= 3 && c <= 6);
      exp_cnt = (c <= 3) ? c : ((7 - c) > 0 ? 7 - c : 0);
      n_cmp++; if (out_valid !== exp_v) begin n_err++; $display("FAIL stream_valid c%0d: got %0b want %0b", c, out_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (out_data !== W'(7 + c)) begin n_err++; $display("FAIL stream_data c%0d: got %0d want %0d", c, out_data, 7 + c); end
      end
      n_cmp++; if (count !== CW'(exp_cnt)) begin n_err++; $display("FAIL stream_count c%0d: got %0d want %0d", c, count, exp_cnt); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c%0d: got %0b want 1", c, in_ready); end
      if (int'(count) > peak) peak = int'(count);
      tick();
    end
    in_valid = 0;
    n_cmp++; if (peak != 3) begin n_err++; $display("FAIL stream_peak: got %0d want 3", peak); end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0;
    out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1; in_data = W'(sent + 1);
      #1;
      if (c < 3) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept c%0d: got %0b want 1", c, in_ready); end
      end else begin
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_ready c%0d: got %0b want 0", c, in_ready); end
        n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL stall_count c%0d: got %0d want 3", c, count); end
        n_cmp++; if (out_data !== W'(1)) begin n_err++; $display("FAIL stall_hold c%0d: got %0d want 1", c, out_data); end
      end
      if (in_ready) sent++;
      tick();
    end
    n_cmp++; if (sent != 3) begin n_err++; $display("FAIL stall_sent: got %0d want 3", sent); end
    out_ready = 1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      in_valid = (sent < 5); in_data = W'(sent + 1);
      #1;
      if (out_valid) begin
        n_cmp++; if (out_data !== W'(got + 1)) begin n_err++; $display("FAIL stall_order: got %0d want %0d", out_data, got + 1); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 0;
    n_cmp++; if (got != 5) begin n_err++; $display("FAIL stall_drain: got %0d want 5", got); end
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL stall_empty: got v%0b c%0d want v0 c0", out_valid, count); end
    tick();
  endtask

  task automatic test_bubbles();
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0 || c == 3);
      in_data  = (c == 0) ? W'(20) : W'(21);
      tick();
    end
    in_valid = 0;
    #1;
    n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL bubble_count: got %0d want 2", count); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(20)) begin n_err++; $display("FAIL bubble_head: got v%0b d%0d want v1 d20", out_valid, out_data); end
    out_ready = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(20)) begin n_err++; $display("FAIL bubble_out0: got v%0b d%0d want v1 d20", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(21)) begin n_err++; $display("FAIL bubble_out1: got v%0b d%0d want v1 d21", out_valid, out_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL bubble_empty: got v%0b c%0d want v0 c0", out_valid, count); end
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_data = W'(30 + c);
      tick();
    end
    flush = 1; in_valid = 1; in_data = W'(99);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %0b want 0", in_ready); end
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL flush_pre_count: got %0d want 3", count); end
    tick();
    flush = 0; in_valid = 0;
    #1;
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %0b want 0", out_valid); end
    n_cmp++; if (out_data !== W'(30)) begin n_err++; $display("FAIL flush_data_hold: got %0d want 30", out_data); end
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL flush_no_emit: got %0d beats want 0", seen); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1; in_data = W'(40 + c);
      tick();
    end
    in_valid = 0; reset = 1;
    tick();
    reset = 0; out_ready = 1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count !== '0 || out_data !== RV) begin n_err++; $display("FAIL midreset: got v%0b c%0d d%0h want v0 c0 d%0h", out_valid, count, out_data, RV); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_emit: got %0b want 0", out_valid); end
  endtask
`else
  task automatic test_skid();
    int got = 0;
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_data = W'(c + 1);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_accept c%0d: got %0b want 1", c, in_ready); end
      tick();
    end
    in_data = W'(4);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_full_ready: got %0b want 0", in_ready); end
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL skid_count: got %0d want 3", count); end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_comb_ready: got %0b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== W'(1)) begin n_err++; $display("FAIL skid_out1: got v%0b d%0d want v1 d1", out_valid, out_data); end
    tick();
    out_ready = 0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_reopen: got %0b want 1", in_ready); end
    n_cmp++; if (count !== CW'(2)) begin n_err++; $display("FAIL skid_count2: got %0d want 2", count); end
    tick();
    in_valid = 0;
    #1;
    n_cmp++; if (count !== CW'(3) || in_ready !== 1'b0) begin n_err++; $display("FAIL skid_refill: got c%0d r%0b want c3 r0", count, in_ready); end
    out_ready = 1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      #1;
      if (out_valid) begin
        n_cmp++; if (out_data !== W'(got + 2)) begin n_err++; $display("FAIL skid_order: got %0d want %0d", out_data, got + 2); end
        got++;
      end
      tick();
    end
    n_cmp++; if (got != 3) begin n_err++; $display("FAIL skid_drain: got %0d want 3", got); end
    n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_err++; $display("FAIL skid_empty: got c%0d v%0b want c0 v0", count, out_valid); end
  endtask
`endif

  initial begin
    test_reset();
`ifndef ELASTIC_PIPE_SKID_EN
    test_streaming();
    test_stall();
    test_bubbles();
    test_flush();
    test_reset_midstream();
`else
    test_skid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
